// File: rtl/array_arbiter_pkg.sv
// Shared constants for the number-buffer arbiter: syscall opcodes, buffer
// geometry and FSM state encoding.
package array_arbiter_pkg;

  localparam int SYS_OP_LENGTH = 4;

  localparam logic [SYS_OP_LENGTH-1:0] SYSCALL_OUTPUT_INT = 4'd1;
  localparam logic [SYS_OP_LENGTH-1:0] SYSCALL_INPUT_INT  = 4'd5;

  localparam int ARRAY_SIZE = 16;
  localparam int NUM_SIZE   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYS  = 2'd1,
    USR  = 2'd2,
    ACK  = 2'd3
  } state_e;

endpackage

// File: rtl/array_arbiter_rr2.sv
// Two-way round-robin grant (a = sys, b = usr). The pointer only moves when
// upd_en is high, so a lone requester never disturbs the fairness order.
module arb_rr2 (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic upd_en,
  output logic gnt_a,
  output logic gnt_b
);

  logic ptr_q, ptr_d;

  assign gnt_a = req_a & (~req_b | ~ptr_q);
  assign gnt_b = req_b & (~req_a |  ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (upd_en) ptr_d = gnt_a;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/array_arbiter.sv
// Serialises CPU syscall and user-confirm accesses onto the number buffer.
// Define ARRAY_ARB_FIXED_PRIO_EN to give sys strict priority over usr.
module array_arbiter #(
  parameter int ARRAY_SIZE = array_arbiter_pkg::ARRAY_SIZE,
  parameter int NUM_SIZE   = array_arbiter_pkg::NUM_SIZE,
  parameter int IDX_W      = 4,
  parameter int SYS_OP_W   = array_arbiter_pkg::SYS_OP_LENGTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                sys_req,
  input  logic [SYS_OP_W-1:0] sys_op,
  input  logic [31:0]         sys_wdata,
  output logic [31:0]         sys_rdata,
  output logic                sys_ack,
  output logic                sys_bad_op,
  input  logic                usr_req,
  input  logic [IDX_W-1:0]    usr_idx,
  input  logic [NUM_SIZE-1:0] usr_wdata,
  output logic                usr_ack,
  input  logic [IDX_W-1:0]    disp_idx,
  output logic [NUM_SIZE-1:0] disp_data,
  output logic [IDX_W-1:0]    seq_idx,
  output logic                busy
);

  import array_arbiter_pkg::*;

  state_e              state_q, state_d;
  logic                gnt_usr_q, gnt_usr_d;
  logic [IDX_W-1:0]    seq_q, seq_d;
  logic [NUM_SIZE-1:0] rdata_q, rdata_d;
  logic [NUM_SIZE-1:0] disp_q, disp_d;
  logic                sys_ack_q, sys_ack_d;
  logic                usr_ack_q, usr_ack_d;
  logic                bad_op_q, bad_op_d;
  logic                arm_sys_q, arm_sys_d;
  logic                arm_usr_q, arm_usr_d;
  logic [NUM_SIZE-1:0] arr_q [ARRAY_SIZE];
  logic [NUM_SIZE-1:0] arr_d [ARRAY_SIZE];

  logic             elig_sys, elig_usr, gnt_sys, gnt_usr;
  logic             usr_in_range, disp_in_range;
  logic [IDX_W-1:0] seq_inc;
  logic             unused_wdata_hi;

  assign unused_wdata_hi = ^sys_wdata[31:NUM_SIZE];

  assign elig_sys = sys_req & arm_sys_q;
  assign elig_usr = usr_req & arm_usr_q;

`ifdef ARRAY_ARB_FIXED_PRIO_EN
  assign gnt_sys = elig_sys;
  assign gnt_usr = elig_usr & ~elig_sys;
`else
  arb_rr2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req_a  (elig_sys),
    .req_b  (elig_usr),
    .upd_en ((state_q == IDLE) & elig_sys & elig_usr & ~clr),
    .gnt_a  (gnt_sys),
    .gnt_b  (gnt_usr)
  );
`endif

  // Range checks only exist when the index space is wider than the buffer.
  generate
    if (ARRAY_SIZE == (1 << IDX_W)) begin : g_full_idx
      assign usr_in_range  = 1'b1;
      assign disp_in_range = 1'b1;
    end else begin : g_part_idx
      assign usr_in_range  = (32'(usr_idx) < ARRAY_SIZE);
      assign disp_in_range = (32'(disp_idx) < ARRAY_SIZE);
    end
  endgenerate

  assign seq_inc = (seq_q == IDX_W'(ARRAY_SIZE - 1)) ? '0 : seq_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    gnt_usr_d = gnt_usr_q;
    seq_d     = seq_q;
    rdata_d   = rdata_q;
    arr_d     = arr_q;
    sys_ack_d = 1'b0;
    usr_ack_d = 1'b0;
    bad_op_d  = 1'b0;
    arm_sys_d = arm_sys_q;
    arm_usr_d = arm_usr_q;

    case (state_q)
      IDLE: begin
        if (gnt_sys) begin
          state_d   = SYS;
          gnt_usr_d = 1'b0;
        end else if (gnt_usr) begin
          state_d   = USR;
          gnt_usr_d = 1'b1;
        end
      end
      SYS: begin
        if (sys_op == SYS_OP_W'(SYSCALL_INPUT_INT)) begin
          rdata_d = arr_q[seq_q];
          seq_d   = seq_inc;
        end else if (sys_op == SYS_OP_W'(SYSCALL_OUTPUT_INT)) begin
          arr_d[seq_q] = sys_wdata[NUM_SIZE-1:0];
          seq_d        = seq_inc;
        end else begin
          bad_op_d = 1'b1;
        end
        sys_ack_d = 1'b1;
        state_d   = ACK;
      end
      USR: begin
        if (usr_in_range) arr_d[usr_idx] = usr_wdata;
        usr_ack_d = 1'b1;
        state_d   = ACK;
      end
      default: state_d = IDLE;
    endcase

    // A held request stays disarmed until its req has been seen low.
    if (state_q == ACK && !gnt_usr_q) arm_sys_d = 1'b0;
    else if (!sys_req)                arm_sys_d = 1'b1;
    if (state_q == ACK && gnt_usr_q)  arm_usr_d = 1'b0;
    else if (!usr_req)                arm_usr_d = 1'b1;

    if (clr) begin
      state_d   = IDLE;
      seq_d     = '0;
      rdata_d   = rdata_q;
      arr_d     = arr_q;
      sys_ack_d = 1'b0;
      usr_ack_d = 1'b0;
      bad_op_d  = 1'b0;
      arm_sys_d = 1'b1;
      arm_usr_d = 1'b1;
    end

    disp_d = disp_in_range ? arr_d[disp_idx] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_usr_q <= 1'b0;
      seq_q     <= '0;
      rdata_q   <= '0;
      disp_q    <= '0;
      sys_ack_q <= 1'b0;
      usr_ack_q <= 1'b0;
      bad_op_q  <= 1'b0;
      arm_sys_q <= 1'b1;
      arm_usr_q <= 1'b1;
      for (int i = 0; i < ARRAY_SIZE; i++) arr_q[i] <= NUM_SIZE'(ARRAY_SIZE - i);
    end else begin
      state_q   <= state_d;
      gnt_usr_q <= gnt_usr_d;
      seq_q     <= seq_d;
      rdata_q   <= rdata_d;
      disp_q    <= disp_d;
      sys_ack_q <= sys_ack_d;
      usr_ack_q <= usr_ack_d;
      bad_op_q  <= bad_op_d;
      arm_sys_q <= arm_sys_d;
      arm_usr_q <= arm_usr_d;
      arr_q     <= arr_d;
    end
  end

  assign sys_rdata  = {{(32 - NUM_SIZE){1'b0}}, rdata_q};
  assign sys_ack    = sys_ack_q;
  assign sys_bad_op = bad_op_q;
  assign usr_ack    = usr_ack_q;
  assign disp_data  = disp_q;
  assign seq_idx    = seq_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_array_arbiter.sv
// Scoreboarded bench for array_arbiter: a transaction-level buffer model
// predicts each acknowledgement; a monitor checks them as they appear.
module tb_array_arbiter;
  import array_arbiter_pkg::*;

  logic        clk = 1'b0, rst = 1'b0, clr = 1'b0;
  logic        sys_req = 1'b0, usr_req = 1'b0;
  logic [3:0]  sys_op = '0;
  logic [31:0] sys_wdata = '0;
  logic [31:0] sys_rdata;
  logic        sys_ack, sys_bad_op, usr_ack, busy;
  logic [3:0]  usr_idx = '0, disp_idx = '0, seq_idx;
  logic [15:0] usr_wdata = '0, disp_data;

  array_arbiter dut (
    .clk(clk), .rst(rst), .clr(clr),
    .sys_req(sys_req), .sys_op(sys_op), .sys_wdata(sys_wdata),
    .sys_rdata(sys_rdata), .sys_ack(sys_ack), .sys_bad_op(sys_bad_op),
    .usr_req(usr_req), .usr_idx(usr_idx), .usr_wdata(usr_wdata), .usr_ack(usr_ack),
    .disp_idx(disp_idx), .disp_data(disp_data), .seq_idx(seq_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0, ack_cnt = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the buffer as plain integers, one step per transaction.
  int unsigned m_arr[ARRAY_SIZE];
  int          m_seq;
  logic [31:0] m_rdata;
  bit          m_fav_usr;

  typedef struct {
    bit          is_sys;
    bit          bad;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  function automatic void m_reset();
    for (int i = 0; i < ARRAY_SIZE; i++) m_arr[i] = ARRAY_SIZE - i;
    m_seq = 0; m_rdata = 0; m_fav_usr = 0;
  endfunction

  function automatic exp_t m_sys(logic [3:0] op, logic [31:0] wd);
    exp_t e;
    e.is_sys = 1; e.bad = 0;
    if (op == SYSCALL_INPUT_INT) begin
      m_rdata = m_arr[m_seq];
      m_seq   = (m_seq + 1) % ARRAY_SIZE;
    end else if (op == SYSCALL_OUTPUT_INT) begin
      m_arr[m_seq] = wd & 32'hFFFF;
      m_seq        = (m_seq + 1) % ARRAY_SIZE;
    end else begin
      e.bad = 1;
    end
    e.rdata = m_rdata;
    return e;
  endfunction

  function automatic exp_t m_usr(int idx, logic [15:0] d);
    exp_t e;
    if (idx < ARRAY_SIZE) m_arr[idx] = d;
    e.is_sys = 0; e.bad = 0; e.rdata = m_rdata;
    return e;
  endfunction

  // Monitor: every ack must match the oldest prediction.
  initial forever begin
    @(negedge clk);
    if (rst && (sys_ack || usr_ack)) begin
      exp_t e;
      ack_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", {30'd0, sys_ack, usr_ack}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] ack %s bad=%0b rdata=%0h (exp %s bad=%0b rdata=%0h)",
                 sys_ack ? "sys" : "usr", sys_bad_op, sys_rdata,
                 e.is_sys ? "sys" : "usr", e.bad, e.rdata);
        chk("ack_sys", sys_ack, e.is_sys);
        chk("ack_usr", usr_ack, !e.is_sys);
        chk("bad_op", sys_bad_op, e.bad);
        chk("sys_rdata", sys_rdata, e.rdata);
      end
    end else if (rst && sys_bad_op) begin
      chk("bad_op_without_ack", sys_bad_op, 1'b0);
    end
  end

  // Issue one transaction (sys, usr or both raised together) from idle.
  task automatic do_txn(bit ws, bit wu, logic [3:0] op, logic [31:0] wd,
                        logic [3:0] ui, logic [15:0] ud);
    bit usr_first = 0, got_s, got_u;
    int start, nack = 0;
    if (ws && wu) begin
`ifdef ARRAY_ARB_FIXED_PRIO_EN
      usr_first = 0;
`else
      usr_first = m_fav_usr;
      m_fav_usr = !m_fav_usr;
`endif
    end
    if (ws && !usr_first) exp_q.push_back(m_sys(op, wd));
    if (wu)               exp_q.push_back(m_usr(int'(ui), ud));
    if (ws && usr_first)  exp_q.push_back(m_sys(op, wd));
    sys_op = op; sys_wdata = wd; usr_idx = ui; usr_wdata = ud;
    sys_req = ws; usr_req = wu;
    start = cyc; got_s = !ws; got_u = !wu;
    for (int k = 0; k < 30 && !(got_s && got_u); k++) begin
      @(negedge clk);
      if ((sys_ack && !got_s) || (usr_ack && !got_u)) begin
        chk("ack_latency", cyc - start, (nack == 0) ? 2 : 5);
        nack++;
      end
      if (sys_ack && !got_s) begin got_s = 1; sys_req = 0; end
      if (usr_ack && !got_u) begin got_u = 1; usr_req = 0; end
    end
    chk("ack_timeout", {30'd0, got_s, got_u}, 32'd3);
    sys_req = 0; usr_req = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic disp_chk(int idx);
    disp_idx = idx[3:0];
    @(negedge clk);
    chk("disp_data", disp_data, m_arr[idx]);
  endtask

  task automatic pulse_clr();
    clr = 1;
    @(negedge clk);
    clr = 0;
    m_seq = 0;
    @(negedge clk);
    chk("seq_after_clr", seq_idx, 0);
  endtask

  initial begin
    int n0, old_seq;
    m_reset();
    // 1: reset state and initial buffer contents
    repeat (2) @(negedge clk);
    chk("rst_seq", seq_idx, 0);
    chk("rst_rdata", sys_rdata, 0);
    chk("rst_disp", disp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {sys_ack, usr_ack, sys_bad_op}, 0);
    rst = 1;
    for (int i = 0; i < ARRAY_SIZE; i++) disp_chk(i);

    // 2: held INPUT_INT request is serviced exactly once
    n0 = ack_cnt;
    exp_q.push_back(m_sys(SYSCALL_INPUT_INT, 0));
    sys_op = SYSCALL_INPUT_INT; sys_req = 1;
    repeat (5) @(negedge clk);
    sys_req = 0;
    repeat (2) @(negedge clk);
    chk("held_req_ack_count", ack_cnt - n0, 1);
    chk("held_req_rdata", sys_rdata, 16);
    chk("held_req_seq", seq_idx, 1);

    // 3: alternating OUTPUT/INPUT across the wrap point
    pulse_clr();
    for (int k = 0; k < 17; k++)
      do_txn(1, 0, (k % 2 == 0) ? SYSCALL_OUTPUT_INT : SYSCALL_INPUT_INT,
             32'(100 + k), 0, 0);
    chk("wrap_seq", seq_idx, 1);
    disp_chk(0);
    chk("wrap_arr0", disp_data, 116);

    // 4: simultaneous requests, two rounds
    do_txn(1, 1, SYSCALL_INPUT_INT, 0, 4'd3, 16'hABCD);
    do_txn(1, 1, SYSCALL_INPUT_INT, 0, 4'd3, 16'hABCD);
    disp_chk(3);

    // 5: clr during the SYS cycle aborts the write
    old_seq = m_seq;
    sys_op = SYSCALL_OUTPUT_INT; sys_wdata = 32'h5555; sys_req = 1;
    @(negedge clk);
    chk("clr_busy_in_sys", busy, 1);
    clr = 1; sys_req = 0;
    @(negedge clk);
    clr = 0; m_seq = 0;
    chk("clr_busy", busy, 0);
    chk("clr_seq", seq_idx, 0);
    repeat (2) @(negedge clk);
    disp_chk(old_seq);

    // 6: unsupported opcode, then reset in the middle of ACK
    do_txn(1, 0, 4'hF, 32'h1234, 0, 0);
    chk("bad_op_seq", seq_idx, m_seq);
    disp_chk(m_seq);
    sys_op = SYSCALL_INPUT_INT; sys_req = 1;
    @(posedge clk); @(posedge clk); #1;
    chk("ack_before_rst", sys_ack, 1);
    rst = 0; #1;
    chk("midrst_ack", sys_ack, 0);
    chk("midrst_seq", seq_idx, 0);
    chk("midrst_rdata", sys_rdata, 0);
    chk("midrst_disp", disp_data, 0);
    chk("midrst_busy", busy, 0);
    sys_req = 0;
    repeat (2) @(negedge clk);
    rst = 1; m_reset();
    disp_chk(0);

    // Randomised mix against the model
    for (int t = 0; t < 40; t++) begin
      int kind = $urandom_range(0, 2);
      int r = $urandom_range(0, 9);
      logic [3:0] op;
      op = (r < 4) ? SYSCALL_INPUT_INT : (r < 8) ? SYSCALL_OUTPUT_INT
                                               : 4'(8 + $urandom_range(0, 7));
      do_txn(kind != 1, kind != 0, op, $urandom, 4'($urandom_range(0, 15)),
             16'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      disp_chk($urandom_range(0, ARRAY_SIZE - 1));
      if (t % 8 == 7) chk("rand_seq", seq_idx, m_seq);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
